// File: rtl/aircon_pkg.sv
// aircon_pkg: mode enum, display codes and helpers shared by the aircon controller
package aircon_pkg;
  localparam logic [3:0] THERMO_OFF       = 4'b0000;
  localparam logic [3:0] THERMO_LOW_FAN   = 4'b0001;
  localparam logic [3:0] THERMO_HIGH_FAN  = 4'b0010;
  localparam logic [3:0] THERMO_LOW_COOL  = 4'b0100;
  localparam logic [3:0] THERMO_HIGH_COOL = 4'b1000;
  typedef enum logic [3:0] {
    OFF       = THERMO_OFF,
    LOW_FAN   = THERMO_LOW_FAN,
    HIGH_FAN  = THERMO_HIGH_FAN,
    LOW_COOL  = THERMO_LOW_COOL,
    HIGH_COOL = THERMO_HIGH_COOL
  } mode_t;
  function automatic logic is_cool(mode_t m);
    return (m == LOW_COOL) || (m == HIGH_COOL);
  endfunction
endpackage

// File: rtl/btn_edge_det.sv
// btn_edge_det: registered rising-edge detector for one button level
module btn_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lvl,
  output logic o_edge
);
  logic r_prev;
  // previous level, cleared on reset so a held button yields one edge afterwards
  always_ff @(posedge i_clk) r_prev <= i_rst ? 1'b0 : i_lvl;
  assign o_edge = i_lvl & ~r_prev;
endmodule

// File: rtl/aircon_mode_ctrl.sv
// aircon_mode_ctrl: button-driven mode FSM with dwell, compressor lockout and turbo timeout
module aircon_mode_ctrl
  import aircon_pkg::*;
#(
  parameter int DWELL_CYC   = 4,
  parameter int LOCKOUT_CYC = 16,
  parameter int TURBO_CYC   = 32,
  parameter int CNT_W       = 8
) (
  input  logic       Clk_In,
  input  logic       Rst_In,
  input  logic       Power_In,
  input  logic       Up_In,
  input  logic       Down_In,
  input  logic       Turbo_In,
  output logic [3:0] Thermo_Out,
  output logic       Turbo_Out,
  output logic       Busy_Out,
  output logic       Lock_Out
);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TURBO_LD = CNT_W'(TURBO_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  logic w_up, w_dn, w_tb;
  logic w_busy, w_lock, w_up_ok, w_dn_ok;
  mode_t r_state, w_state_nxt, w_up_mode, w_dn_mode;
  logic r_turbo, w_turbo_nxt;
  logic [CNT_W-1:0] r_dwell, r_lock, r_tcnt, w_dwell_nxt, w_lock_nxt, w_tcnt_nxt;
  btn_edge_det u_up (.i_clk(Clk_In), .i_rst(Rst_In), .i_lvl(Up_In),    .o_edge(w_up));
  btn_edge_det u_dn (.i_clk(Clk_In), .i_rst(Rst_In), .i_lvl(Down_In),  .o_edge(w_dn));
  btn_edge_det u_tb (.i_clk(Clk_In), .i_rst(Rst_In), .i_lvl(Turbo_In), .o_edge(w_tb));
  assign w_busy = r_dwell != '0;
  assign w_lock = r_lock != '0;
  // next mode, saturating counters and turbo flag; power-off overrides everything
  always_comb begin
    w_up_mode   = (r_state == OFF) ? LOW_FAN : (r_state == LOW_FAN) ? HIGH_FAN :
                  (r_state == HIGH_FAN) ? LOW_COOL : HIGH_COOL;
    w_dn_mode   = (r_state == HIGH_COOL) ? LOW_COOL : (r_state == LOW_COOL) ? HIGH_FAN :
                  (r_state == HIGH_FAN) ? LOW_FAN : OFF;
    w_up_ok     = Power_In && w_up && !w_dn && !w_busy && (r_state != HIGH_COOL) &&
                  !((r_state == HIGH_FAN) && w_lock);
    w_dn_ok     = Power_In && w_dn && !w_up && !w_busy && (r_state != OFF);
    w_state_nxt = !Power_In ? OFF : w_up_ok ? w_up_mode : w_dn_ok ? w_dn_mode : r_state;
    w_dwell_nxt = !Power_In ? '0 : (w_up_ok || w_dn_ok) ? DWELL_LD :
                  w_busy ? r_dwell - ONE : r_dwell;
    w_lock_nxt  = (is_cool(r_state) && !is_cool(w_state_nxt)) ? LOCK_LD :
                  w_lock ? r_lock - ONE : r_lock;
    w_turbo_nxt = (w_state_nxt == OFF) ? 1'b0 :
                  r_turbo ? !(w_tb || (r_tcnt == '0)) : (w_tb && (r_state != OFF));
    w_tcnt_nxt  = (w_turbo_nxt && !r_turbo) ? TURBO_LD :
                  (r_tcnt != '0) ? r_tcnt - ONE : r_tcnt;
  end
  // state and counter registers
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      r_state <= OFF;
      r_turbo <= 1'b0;
      r_dwell <= '0;
      r_lock  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_turbo <= w_turbo_nxt;
      r_dwell <= w_dwell_nxt;
      r_lock  <= w_lock_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end
  assign Thermo_Out = r_state;
  assign Turbo_Out  = r_turbo;
  assign Busy_Out   = w_busy;
  assign Lock_Out   = w_lock;
endmodule

// File: doc/aircon_mode_ctrl.md
Name: aircon_mode_ctrl

Overview:
- Sequential controller that drives the aircon thermostat bar-graph display block.
- Converts Up/Down/Turbo button levels into the legal one-hot mode code and turbo flag that the display block consumes.
- Enforces a minimum mode dwell time, a compressor lockout after leaving cooling, and turbo auto-timeout.
- Never emits a code that the display block treats as an error.

Parameters:
- DWELL_CYC, 4: minimum cycles between accepted mode changes.
- LOCKOUT_CYC, 16: cycles after leaving a COOL mode during which COOL modes may not be entered.
- TURBO_CYC, 32: cycles after which an active turbo auto-clears.
- CNT_W, 8: width of each internal counter. Must satisfy 2^CNT_W > max(DWELL_CYC, LOCKOUT_CYC, TURBO_CYC).

Ports:
- Clk_In  in  1  system clock, rising edge.
- Rst_In  in  1  synchronous active-high reset.
- Power_In  in  1  level; 0 forces OFF.
- Up_In  in  1  button level; a rising edge requests the next higher mode.
- Down_In  in  1  button level; a rising edge requests the next lower mode.
- Turbo_In  in  1  button level; a rising edge toggles turbo.
- Thermo_Out  out  4  mode code: 0000 OFF, 0001 LOW_FAN, 0010 HIGH_FAN, 0100 LOW_COOL, 1000 HIGH_COOL.
- Turbo_Out  out  1  turbo active.
- Busy_Out  out  1  dwell timer running; Up/Down edges are ignored.
- Lock_Out  out  1  compressor lockout active.

Behaviour:
- Reset: all outputs are 0, state is OFF, all counters are 0, and the edge-detect registers are loaded with 0.
  - A button held high through reset therefore produces one edge on the first post-reset cycle.
- Edge detect: a registered previous level per button. An edge is cur & ~prev.
- Latency: an edge sampled on cycle N updates the outputs on cycle N+1.
- Mode FSM states: OFF -> LOW_FAN -> HIGH_FAN -> LOW_COOL -> HIGH_COOL, linear order.
  - Up edge moves one step up; Down edge moves one step down.
  - Saturates at both ends: no wrap, and no dwell restart on a saturated request.
- Up and Down edges in the same cycle: both are ignored and there is no state change.
- Dwell: every accepted mode change loads the dwell counter with DWELL_CYC-1. Busy_Out = (counter != 0).
  - Up/Down edges while Busy_Out=1 are dropped, not queued.
- Lockout: on any transition from LOW_COOL/HIGH_COOL to a non-COOL state, the lockout counter is loaded with LOCKOUT_CYC-1. Lock_Out = (counter != 0).
  - An Up edge in HIGH_FAN while Lock_Out=1 is refused. The state stays HIGH_FAN and the dwell counter is not loaded.
- Power_In=0: the next state is OFF from any state, regardless of dwell.
  - Turbo clears and the dwell counter clears.
  - Lockout is loaded if leaving a COOL mode. Otherwise the lockout counter keeps counting down.
  - Up/Down/Turbo edges are ignored while Power_In=0.
- Turbo:
  - A Turbo edge in a non-OFF state toggles Turbo_Out. Setting turbo loads the turbo counter with TURBO_CYC-1.
  - When the counter reaches 0 with turbo set, turbo clears on the following cycle.
  - A Turbo edge in OFF is ignored.
  - Entering OFF clears turbo.
  - Mode changes do not affect turbo or its counter.
  - A Turbo edge coinciding with the final timeout cycle clears turbo; there is no re-arm.
- Counters: saturate at 0, never underflow.
- Output encoding: Thermo_Out is registered and always one of the five legal codes.
- Turbo_Out is registered and is 0 whenever Thermo_Out = 0000.

Decomposition:
- Shared package aircon_pkg holds:
  - the mode enum (OFF, LOW_FAN, HIGH_FAN, LOW_COOL, HIGH_COOL);
  - the mode-to-Thermo code localparams, for reuse by the display block bench;
  - an is_cool() function.
- One natural sub-module: btn_edge_det, one instance per button. It is a 1-bit registered rising-edge detector with synchronous reset.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset then Power_In=1 with Up pulsed every 5 cycles, 4 times -> Thermo_Out steps 0001, 0010, 0100, 1000, each one cycle after its edge. A 5th Up leaves it at 1000.
- From LOW_FAN, issue a second Up edge 2 cycles after the first -> Busy_Out=1, edge dropped, Thermo_Out stays 0010.
- From HIGH_COOL, Down×2 to 0010, then Up 5 cycles later -> Lock_Out=1, Thermo_Out stays 0010. Up again after Lock_Out falls (16 cycles after leaving 0100) -> 0100.
- In LOW_FAN, Turbo edge -> Turbo_Out=1 next cycle, then auto-clears after 32 cycles. A Turbo edge in OFF -> Turbo_Out stays 0.
- In HIGH_COOL with turbo set, drop Power_In -> next cycle Thermo_Out=0000, Turbo_Out=0, Lock_Out=1.
- Up and Down rising in the same cycle from HIGH_FAN -> no change, Busy_Out stays 0. Assert Rst_In mid-dwell -> all outputs 0 next cycle.
